// File: rtl/pe_sequencer.sv
// Per-PE job sequencer: streams LEN kernel/neuron pairs into the local stores,
// sweeps them to drive the MAC, then holds the result until it is taken.
module pe_sequencer #(
  parameter int A = 7,
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  input  logic [A-1:0] len,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] kernel_in,
  input  logic [W-1:0] neuron_in,
  output logic [W-1:0] kernel_data,
  output logic [W-1:0] neuron_data,
  output logic [A-1:0] store_addr,
  output logic         store_write,
  output logic         mac_clear,
  output logic         mac_en,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [A-1:0] CNT_ONE  = {{(A-1){1'b0}}, 1'b1};
  localparam logic [A-1:0] CNT_ZERO = '0;

  logic [2:0]   state_q, state_d;
  logic [A-1:0] cnt_q, cnt_d;
  logic [A-1:0] len_q, len_d;
  logic         mac_en_q;
  logic         last_elem;
  logic         handshake;

  // len_q is never zero in LOAD/COMPUTE, so len_q-1 cannot underflow there.
  assign last_elem = (cnt_q == (len_q - CNT_ONE));
  assign handshake = in_valid && (state_q == S_LOAD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = len;
          cnt_d   = CNT_ZERO;
          state_d = (len == CNT_ZERO) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (handshake) begin
          if (last_elem) begin
            cnt_d   = CNT_ZERO;
            state_d = S_COMPUTE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      S_COMPUTE: begin
        if (last_elem) begin
          cnt_d   = CNT_ZERO;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // mac_en trails each COMPUTE read address by one cycle to match store read latency.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      len_q    <= CNT_ZERO;
      mac_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      mac_en_q <= (state_q == S_COMPUTE);
    end
  end

  assign in_ready    = (state_q == S_LOAD);
  assign store_write = handshake;
  assign store_addr  = cnt_q;
  assign kernel_data = kernel_in;
  assign neuron_data = neuron_in;
  // Gated by RST_N so the pulse cannot appear while reset is held.
  assign mac_clear   = RST_N && (state_q == S_IDLE) && start;
  assign mac_en      = mac_en_q;
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_DONE);

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer with a behavioural model of the PE stores and MAC.
module tb_pe_sequencer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        start;
  logic [6:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] kernel_in;
  logic [15:0] neuron_in;
  logic [15:0] kernel_data;
  logic [15:0] neuron_data;
  logic [6:0]  store_addr;
  logic        store_write;
  logic        mac_clear;
  logic        mac_en;
  logic        busy;
  logic        out_valid;
  logic        out_ready;

  int vectors = 0;
  int errors  = 0;

  pe_sequencer #(.A(7), .W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready),
    .kernel_in(kernel_in), .neuron_in(neuron_in),
    .kernel_data(kernel_data), .neuron_data(neuron_data),
    .store_addr(store_addr), .store_write(store_write),
    .mac_clear(mac_clear), .mac_en(mac_en), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 CLK = ~CLK;

  // PE environment: two synchronous-read stores and an accumulator.
  logic [15:0] mem_k [0:127];
  logic [15:0] mem_n [0:127];
  logic [15:0] rd_k, rd_n;
  logic [31:0] acc = 32'd0;
  int wr_pulses  = 0;
  int mac_pulses = 0;

  always @(posedge CLK) begin
    if (store_write) begin
      mem_k[store_addr] <= kernel_data;
      mem_n[store_addr] <= neuron_data;
      wr_pulses <= wr_pulses + 1;
    end
    rd_k <= mem_k[store_addr];
    rd_n <= mem_n[store_addr];
    if (mac_clear) acc <= 32'd0;
    else if (mac_en) acc <= acc + 32'(rd_k) * 32'(rd_n);
    if (mac_en) mac_pulses <= mac_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Returns at posedge+2, where the next cycle's inputs are driven.
  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic start_job(input logic [6:0] l);
    start = 1'b1;
    len   = l;
    settle();
    check("start_mac_clear", 32'(mac_clear), 32'd1);
    check("start_busy", 32'(busy), 32'd0);
    cyc();
    start = 1'b0;
    len   = 7'h55;
  endtask

  task automatic push(input logic [15:0] k, input logic [15:0] n, input int exp_addr);
    in_valid  = 1'b1;
    kernel_in = k;
    neuron_in = n;
    settle();
    check("load_addr", 32'(store_addr), 32'(exp_addr));
    check("load_write", 32'(store_write), 32'd1);
    check("load_kdata", 32'(kernel_data), 32'(k));
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat, output logic [6:0] max_a);
    int n = 0;
    max_a = 7'd0;
    settle();
    while (!out_valid && n < 400) begin
      if (store_addr > max_a) max_a = store_addr;
      cyc();
      settle();
      n++;
    end
    check("done_latency", 32'(n), 32'(exp_lat));
  endtask

  task automatic finish_job();
    out_ready = 1'b1;
    settle();
    check("finish_out_valid", 32'(out_valid), 32'd1);
    cyc();
    out_ready = 1'b0;
    settle();
    check("finish_idle_busy", 32'(busy), 32'd0);
    check("finish_idle_valid", 32'(out_valid), 32'd0);
  endtask

  logic [6:0] max_a;
  int snap_w, snap_m;
  logic vpat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int   apat [6] = '{0, 1, 1, 1, 2, 2};

  initial begin
    RST_N = 1'b0; start = 1'b0; len = 7'd0; in_valid = 1'b0;
    kernel_in = 16'd0; neuron_in = 16'd0; out_ready = 1'b0;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(store_addr), 32'd0);
    check("rst_mac_en", 32'(mac_en), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    #4 RST_N = 1'b1;
    cyc();

    // in_valid in IDLE is not accepted
    in_valid = 1'b1;
    settle();
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_store_write", 32'(store_write), 32'd0);
    in_valid = 1'b0;

    // Test 1: len=4, back-to-back pairs
    snap_w = wr_pulses; snap_m = mac_pulses;
    start_job(7'd4);
    for (int i = 0; i < 4; i++) push(16'(i + 1), 16'(i + 5), i);
    settle();
    check("t1_compute_in_ready", 32'(in_ready), 32'd0);
    for (int j = 0; j < 4; j++) begin
      check("t1_compute_addr", 32'(store_addr), 32'(j));
      check("t1_compute_mac_en", 32'(mac_en), (j != 0) ? 32'd1 : 32'd0);
      cyc();
      settle();
    end
    check("t1_drain_mac_en", 32'(mac_en), 32'd1);
    check("t1_drain_out_valid", 32'(out_valid), 32'd0);
    cyc();
    settle();
    check("t1_done_out_valid", 32'(out_valid), 32'd1);
    check("t1_done_mac_en", 32'(mac_en), 32'd0);
    check("t1_result", acc, 32'd70);
    check("t1_writes", 32'(wr_pulses - snap_w), 32'd4);
    check("t1_macs", 32'(mac_pulses - snap_m), 32'd4);
    finish_job();

    // Test 2: len=3 with gaps in in_valid
    snap_w = wr_pulses;
    start_job(7'd3);
    for (int i = 0; i < 6; i++) begin
      in_valid  = vpat[i];
      kernel_in = 16'(10 + i);
      neuron_in = 16'(i);
      settle();
      check("t2_addr", 32'(store_addr), 32'(apat[i]));
      check("t2_write", 32'(store_write), 32'(vpat[i]));
      check("t2_in_ready", 32'(in_ready), 32'd1);
      cyc();
    end
    in_valid = 1'b0;
    settle();
    check("t2_compute_in_ready", 32'(in_ready), 32'd0);
    wait_done(4, max_a);
    check("t2_writes", 32'(wr_pulses - snap_w), 32'd3);
    check("t2_result", acc, 32'd114);
    finish_job();

    // Test 3: len=0
    snap_w = wr_pulses; snap_m = mac_pulses;
    start_job(7'd0);
    settle();
    check("t3_out_valid", 32'(out_valid), 32'd1);
    check("t3_mac_clear_once", 32'(mac_clear), 32'd0);
    check("t3_busy", 32'(busy), 32'd1);
    finish_job();
    check("t3_writes", 32'(wr_pulses - snap_w), 32'd0);
    check("t3_macs", 32'(mac_pulses - snap_m), 32'd0);

    // Test 4: DONE held with start asserted
    start_job(7'd0);
    start = 1'b1;
    len   = 7'd1;
    for (int i = 0; i < 10; i++) begin
      settle();
      check("t4_hold_out_valid", 32'(out_valid), 32'd1);
      check("t4_hold_mac_clear", 32'(mac_clear), 32'd0);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    settle();
    check("t4_idle_busy", 32'(busy), 32'd0);
    check("t4_idle_out_valid", 32'(out_valid), 32'd0);
    start_job(7'd1);
    settle();
    check("t4_new_job_load", 32'(in_ready), 32'd1);
    push(16'd3, 16'd4, 0);
    wait_done(2, max_a);
    check("t4_result", acc, 32'd12);
    finish_job();

    // Test 5: maximum length
    snap_w = wr_pulses; snap_m = mac_pulses;
    start_job(7'd127);
    for (int i = 0; i < 127; i++) push(16'(i + 1), 16'd1, i);
    wait_done(128, max_a);
    check("t5_max_addr", 32'(max_a), 32'd126);
    check("t5_writes", 32'(wr_pulses - snap_w), 32'd127);
    check("t5_macs", 32'(mac_pulses - snap_m), 32'd127);
    check("t5_result", acc, 32'd8128);
    finish_job();

    // Test 6: asynchronous reset in COMPUTE at cnt=2
    start_job(7'd5);
    for (int i = 0; i < 5; i++) push(16'd1, 16'd1, i);
    cyc();
    cyc();
    settle();
    check("t6_pre_addr", 32'(store_addr), 32'd2);
    check("t6_pre_mac_en", 32'(mac_en), 32'd1);
    RST_N = 1'b0;
    start = 1'b1;
    settle();
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_mac_en", 32'(mac_en), 32'd0);
    check("t6_rst_addr", 32'(store_addr), 32'd0);
    check("t6_rst_mac_clear", 32'(mac_clear), 32'd0);
    check("t6_rst_out_valid", 32'(out_valid), 32'd0);
    #1;
    RST_N = 1'b1;
    start = 1'b0;
    cyc();
    settle();
    check("t6_post_busy", 32'(busy), 32'd0);
    start_job(7'd2);
    push(16'd2, 16'd4, 0);
    push(16'd3, 16'd5, 1);
    wait_done(3, max_a);
    check("t6_result", acc, 32'd23);
    finish_job();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
